masked_gadget_ctrl: RTL and testbench
=====================================

# masked_gadget_ctrl

Sequencer for the share-wise masked gadgets on 8-share, 8-bit boolean-masked data. It accepts one operation (NOT, XOR, AND, REFRESH) on share vectors and drives the gadget datapath for that operation. For AND (ISW) and REFRESH it pulls fresh randomness from an external PRNG over a valid/ready handshake, one byte per step. It sits between the masked S-box datapath and the randomness source and is the single owner of that datapath.

## Interface
Parameters:
- NSHARES, 8, number of shares (masking order NSHARES-1)
- W, 8, bits per share

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  controller can accept a request
- in_op  in  2  0=NOT, 1=XOR, 2=AND, 3=REFRESH
- in_a  in  NSHARES×W  operand A shares, share i at bits [i*W +: W]
- in_b  in  NSHARES×W  operand B shares, ignored for NOT/REFRESH
- rnd_valid  in  1  random byte available
- rnd_ready  out  1  controller consumes random byte this cycle
- rnd_data  in  W  random byte
- out_valid  out  1  result shares valid
- out_ready  in  1  consumer accepts result
- out_c  out  NSHARES×W  result shares

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch operands, then:
  - NOT: c0=~a0, ci=ai for i>0; go to DONE.
  - XOR: ci=ai^bi; go to DONE.
  - AND: ci=ai&bi; clear pair counter (i=0, j=1); go to RUN.
  - REFRESH: ci=ai; clear counter k=1; go to RUN.
- RUN: rnd_ready=1. A step occurs only on rnd_valid&rnd_ready, with r=rnd_data. No step means all state holds.
  - AND step (i,j): ci^=r; cj^=(r^(ai&bj))^(aj&bi). Pairs run row-major: i=0..NSHARES-2, j=i+1..NSHARES-1. That is 28 steps for NSHARES=8. After the step on pair (6,7), go to DONE.
  - REFRESH step k: c0^=r; ck^=r. k runs 1..NSHARES-1, 7 steps. After k=7, go to DONE.
- DONE: out_valid=1, out_c=c. On out_ready, go to IDLE.
- The controller accepts no new request while in RUN or DONE. out_c holds stable while out_valid=1 and out_ready=0.
- Functional invariant: XOR of the out_c shares equals ~A, A^B, A&B, or A for the respective operation, for any randomness values.
- Randomness is never consumed outside RUN. The rnd_ready=1 requirement in RUN is independent of rnd_valid, so there is no combinational path from rnd_valid to rnd_ready.

## Timing
- Reset (asynchronous, any state): state=IDLE, in_ready=1, rnd_ready=0, out_valid=0, out_c=0, counters=0, latched operands=0. Reset mid-RUN aborts the operation, and the partial result is discarded.
- Request accepted at edge N:
  - NOT/XOR: out_valid high in cycle N+1.
  - AND: with rnd_valid held at 1, steps occur at edges N+1..N+28 and out_valid goes high in cycle N+29.
  - REFRESH: out_valid goes high in cycle N+8.
  - Each cycle with rnd_valid=0 in RUN adds exactly one cycle of latency.
- out_valid&out_ready at edge M: in_ready goes high in cycle M+1. There is no same-cycle result-to-request bypass.
- All outputs are registered except in_ready, rnd_ready and out_valid, which are decoded from state only.

## Structure
- Package masked_pkg holds:
  - NSHARES and W
  - NRAND_AND = NSHARES*(NSHARES-1)/2
  - NRAND_REFRESH = NSHARES-1
  - the op enum (OP_NOT, OP_XOR, OP_AND, OP_REFRESH)
  - the state enum
- Sub-module isw_pair_step is purely combinational. Inputs: ai, aj, bi, bj, ci, cj, r. Outputs: updated ci and cj. The controller muxes share i and share j into it using the pair counter.

## Test plan
- NOT: A=8'hAA split into 8 random shares -> recombined out_c=8'h55; out_valid exactly 1 cycle after accept; rnd_ready never asserted.
- XOR: A=8'hAA, B=8'h0F -> recombined 8'hA5, latency 1.
- AND: A=8'hAA, B=8'h0F, rnd_valid=1 with a $random stream -> recombined 8'h0A; exactly 28 random handshakes; out_valid 29 cycles after accept. Repeat with 50 random operand pairs and check against A&B.
- Randomness stall: AND with rnd_valid toggling 1,0,1,0… -> result still 8'h0A; latency 56 cycles (the last random arrives at edge N+55, so out_valid goes high in cycle N+56); state and shares frozen on rnd_valid=0 cycles.
- Backpressure: REFRESH of A=8'h3C with out_ready=0 for 5 cycles -> recombined 8'h3C, the individual shares differ from the input shares, out_c stable, in_ready=0 throughout; in_ready=1 in the cycle after the handshake.
- Reset mid-op: assert rst at the 10th step of an AND -> out_valid=0, out_c=0, in_ready=1 immediately; a following XOR with A=8'hFF, B=8'h0F returns 8'hF0.

Source files
------------

// File: rtl/masked_pkg.sv
// Shared types and sizes for the boolean-masked gadget sequencer.
// Holds the share geometry, randomness budgets, and the op/state enums.
package masked_pkg;

  localparam int NSHARES       = 8;
  localparam int W             = 8;
  localparam int NRAND_AND     = NSHARES * (NSHARES - 1) / 2;
  localparam int NRAND_REFRESH = NSHARES - 1;

  typedef enum logic [1:0] {
    OP_NOT     = 2'd0,
    OP_XOR     = 2'd1,
    OP_AND     = 2'd2,
    OP_REFRESH = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/isw_pair_step.sv
// One ISW cross-term step on share pair (i,j), purely combinational.
// Ports: ai/aj/bi/bj operand shares, ci/cj result shares, r fresh byte.
module isw_pair_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] ai_i,
  input  logic [W-1:0] aj_i,
  input  logic [W-1:0] bi_i,
  input  logic [W-1:0] bj_i,
  input  logic [W-1:0] ci_i,
  input  logic [W-1:0] cj_i,
  input  logic [W-1:0] r_i,
  output logic [W-1:0] ci_o,
  output logic [W-1:0] cj_o
);

  // r is folded in before the second cross term so no intermediate
  // value ever combines both cross products unmasked.
  logic [W-1:0] t;

  assign t    = r_i ^ (ai_i & bj_i);
  assign ci_o = ci_i ^ r_i;
  assign cj_o = cj_i ^ (t ^ (aj_i & bi_i));

endmodule

// File: rtl/masked_gadget_ctrl.sv
// Sequencer for masked NOT/XOR/AND/REFRESH gadgets on shared bytes.
// Ports: in_* request handshake, rnd_* PRNG handshake, out_* result.
module masked_gadget_ctrl
  import masked_pkg::*;
#(
  parameter int NSHARES = masked_pkg::NSHARES,
  parameter int W       = masked_pkg::W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [NSHARES*W-1:0] in_a,
  input  logic [NSHARES*W-1:0] in_b,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  input  logic [W-1:0]         rnd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NSHARES*W-1:0] out_c
);

  localparam int IW = $clog2(NSHARES);

  localparam logic [IW-1:0] LAST   = IW'(NSHARES - 1);
  localparam logic [IW-1:0] LAST_I = IW'(NSHARES - 2);

  state_e state_q, state_d;
  op_e    op_q, op_d;

  logic [NSHARES-1:0][W-1:0] a_q, a_d;
  logic [NSHARES-1:0][W-1:0] b_q, b_d;
  logic [NSHARES-1:0][W-1:0] c_q, c_d;

  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] k_q, k_d;

  logic [W-1:0] ci_n, cj_n;

  isw_pair_step #(.W(W)) u_step (
    .ai_i (a_q[i_q]),
    .aj_i (a_q[j_q]),
    .bi_i (b_q[i_q]),
    .bj_i (b_q[j_q]),
    .ci_i (c_q[i_q]),
    .cj_i (c_q[j_q]),
    .r_i  (rnd_data),
    .ci_o (ci_n),
    .cj_o (cj_n)
  );

  // Handshake outputs depend on state only, so rnd_valid never
  // reaches rnd_ready combinationally.
  assign in_ready  = (state_q == S_IDLE);
  assign rnd_ready = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign out_c     = c_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d  = in_a;
          b_d  = in_b;
          op_d = op_e'(in_op);
          unique case (op_e'(in_op))
            OP_NOT: begin
              c_d     = in_a;
              c_d[0]  = ~c_d[0];
              state_d = S_DONE;
            end
            OP_XOR: begin
              c_d     = in_a ^ in_b;
              state_d = S_DONE;
            end
            OP_AND: begin
              c_d     = in_a & in_b;
              i_d     = '0;
              j_d     = IW'(1);
              state_d = S_RUN;
            end
            OP_REFRESH: begin
              c_d     = in_a;
              k_d     = IW'(1);
              state_d = S_RUN;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_RUN: begin
        if (rnd_valid) begin
          if (op_q == OP_AND) begin
            c_d[i_q] = ci_n;
            c_d[j_q] = cj_n;
            // Row-major walk of the upper triangle.
            if (j_q == LAST) begin
              if (i_q == LAST_I) begin
                state_d = S_DONE;
              end else begin
                i_d = i_q + IW'(1);
                j_d = i_q + IW'(2);
              end
            end else begin
              j_d = j_q + IW'(1);
            end
          end else begin
            c_d[0]   = c_q[0] ^ rnd_data;
            c_d[k_q] = c_q[k_q] ^ rnd_data;
            if (k_q == LAST) begin
              state_d = S_DONE;
            end else begin
              k_d = k_q + IW'(1);
            end
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOT;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_masked_gadget_ctrl.sv
// Directed bench for masked_gadget_ctrl: recombined results,
// latency, randomness handshakes, stalls, backpressure and reset.
module tb_masked_gadget_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        rnd_valid = 1'b0;
  logic        rnd_ready;
  logic [7:0]  rnd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  masked_gadget_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd_data  (rnd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c)
  );

  function automatic logic [63:0] split(input logic [7:0] v);
    logic [63:0] s;
    logic [7:0]  acc;
    s   = '0;
    acc = v;
    for (int i = 1; i < 8; i++) begin
      s[i*8 +: 8] = 8'($urandom);
      acc         = acc ^ s[i*8 +: 8];
    end
    s[7:0] = acc;
    return s;
  endfunction

  function automatic logic [7:0] recomb(input logic [63:0] s);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = acc ^ s[i*8 +: 8];
    return acc;
  endfunction

  // Drives one operation to completion. mode 1: rnd_valid always 1,
  // mode 2: rnd_valid 1,0,1,0... from the edge after accept.
  task automatic run_op(
    input  logic [1:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  int          mode,
    input  int          bp,
    output int          lat,
    output logic [63:0] res,
    output int          hs,
    output int          frz,
    output int          bpbad,
    output logic        ir_after
  );
    int          n;
    logic [63:0] snap;
    logic        chk;
    hs = 0; frz = 0; bpbad = 0; lat = 0;
    res = '0; ir_after = 1'b0;
    snap = '0; chk = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_wait got=0 want=1");
      return;
    end
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    rnd_valid = 1'b1;
    rnd_data  = 8'($urandom_range(1, 255));
    for (int c = 1; c <= 200; c++) begin
      if (rnd_valid && rnd_ready) hs++;
      @(posedge clk); #1;
      if (chk && out_c !== snap) frz++;
      in_valid = 1'b0;
      if (out_valid) begin
        lat = c;
        break;
      end
      rnd_data  = 8'($urandom_range(1, 255));
      rnd_valid = (mode == 2) ? c[0] : 1'b1;
      chk       = !rnd_valid;
      snap      = out_c;
    end
    rnd_valid = 1'b0;
    res = out_c;
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); #1;
      if (out_c !== res || !out_valid || in_ready) bpbad++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ir_after  = in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (rnd_ready !== 1'b0) begin
      failures++; $display("FAIL reset_rnd_ready got=%b want=0", rnd_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_c !== 64'h0) begin
      failures++; $display("FAIL reset_out_c got=%h want=0", out_c);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_not();
    int lat, hs, frz, bpb;
    logic [63:0] res;
    logic ir;
    run_op(2'd0, split(8'hAA), '0, 1, 0, lat, res, hs, frz, bpb, ir);
    checks++;
    if (recomb(res) !== 8'h55) begin
      failures++; $display("FAIL not_value got=%h want=55", recomb(res));
    end
    checks++;
    if (lat !== 1) begin
      failures++; $display("FAIL not_latency got=%0d want=1", lat);
    end
    checks++;
    if (hs !== 0) begin
      failures++; $display("FAIL not_rnd_handshakes got=%0d want=0", hs);
    end
    checks++;
    if (ir !== 1'b1) begin
      failures++; $display("FAIL not_in_ready_after got=%b want=1", ir);
    end
  endtask

  task automatic test_xor();
    int lat, hs, frz, bpb;
    logic [63:0] res;
    logic ir;
    run_op(2'd1, split(8'hAA), split(8'h0F), 1, 0,
           lat, res, hs, frz, bpb, ir);
    checks++;
    if (recomb(res) !== 8'hA5) begin
      failures++; $display("FAIL xor_value got=%h want=a5", recomb(res));
    end
    checks++;
    if (lat !== 1) begin
      failures++; $display("FAIL xor_latency got=%0d want=1", lat);
    end
  endtask

  task automatic test_and();
    int lat, hs, frz, bpb;
    logic [63:0] res;
    logic ir;
    run_op(2'd2, split(8'hAA), split(8'h0F), 1, 0,
           lat, res, hs, frz, bpb, ir);
    checks++;
    if (recomb(res) !== 8'h0A) begin
      failures++; $display("FAIL and_value got=%h want=0a", recomb(res));
    end
    checks++;
    if (hs !== 28) begin
      failures++; $display("FAIL and_rnd_handshakes got=%0d want=28", hs);
    end
    checks++;
    if (lat !== 29) begin
      failures++; $display("FAIL and_latency got=%0d want=29", lat);
    end
  endtask

  task automatic test_and_random();
    int lat, hs, frz, bpb;
    logic [63:0] res;
    logic ir;
    logic [7:0] a, b;
    for (int t = 0; t < 50; t++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      run_op(2'd2, split(a), split(b), 1, 0,
             lat, res, hs, frz, bpb, ir);
      checks++;
      if (recomb(res) !== (a & b)) begin
        failures++;
        $display("FAIL and_rand a=%h b=%h got=%h want=%h",
                 a, b, recomb(res), a & b);
      end
    end
  endtask

  task automatic test_stall();
    int lat, hs, frz, bpb;
    logic [63:0] res;
    logic ir;
    run_op(2'd2, split(8'hAA), split(8'h0F), 2, 0,
           lat, res, hs, frz, bpb, ir);
    checks++;
    if (recomb(res) !== 8'h0A) begin
      failures++; $display("FAIL stall_value got=%h want=0a", recomb(res));
    end
    checks++;
    if (lat !== 56) begin
      failures++; $display("FAIL stall_latency got=%0d want=56", lat);
    end
    checks++;
    if (frz !== 0) begin
      failures++; $display("FAIL stall_frozen changes=%0d want=0", frz);
    end
    checks++;
    if (hs !== 28) begin
      failures++; $display("FAIL stall_rnd_handshakes got=%0d want=28", hs);
    end
  endtask

  task automatic test_backpressure();
    int lat, hs, frz, bpb, same;
    logic [63:0] res, a;
    logic ir;
    a = split(8'h3C);
    run_op(2'd3, a, '0, 1, 5, lat, res, hs, frz, bpb, ir);
    checks++;
    if (recomb(res) !== 8'h3C) begin
      failures++; $display("FAIL refresh_value got=%h want=3c", recomb(res));
    end
    checks++;
    if (lat !== 8) begin
      failures++; $display("FAIL refresh_latency got=%0d want=8", lat);
    end
    checks++;
    if (hs !== 7) begin
      failures++; $display("FAIL refresh_rnd_handshakes got=%0d want=7", hs);
    end
    same = 0;
    for (int i = 1; i < 8; i++) begin
      if (res[i*8 +: 8] === a[i*8 +: 8]) same++;
    end
    checks++;
    if (same !== 0) begin
      failures++; $display("FAIL refresh_shares_unchanged got=%0d want=0", same);
    end
    checks++;
    if (bpb !== 0) begin
      failures++; $display("FAIL backpressure_hold bad_cycles=%0d want=0", bpb);
    end
    checks++;
    if (ir !== 1'b1) begin
      failures++; $display("FAIL backpressure_in_ready got=%b want=1", ir);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, hs, frz, bpb;
    logic [63:0] res;
    logic ir;
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    in_op     = 2'd2;
    in_a      = split(8'hAA);
    in_b      = split(8'h0F);
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int s = 0; s < 10; s++) begin
      rnd_data = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    checks++;
    if (rnd_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_running rnd_ready=%b out_valid=%b want=1,0",
               rnd_ready, out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL midop_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_c !== 64'h0) begin
      failures++; $display("FAIL midop_out_c got=%h want=0", out_c);
    end
    checks++;
    if (in_ready !== 1'b1 || rnd_ready !== 1'b0) begin
      failures++;
      $display("FAIL midop_ready in_ready=%b rnd_ready=%b want=1,0",
               in_ready, rnd_ready);
    end
    rnd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(2'd1, split(8'hFF), split(8'h0F), 1, 0,
           lat, res, hs, frz, bpb, ir);
    checks++;
    if (recomb(res) !== 8'hF0) begin
      failures++; $display("FAIL post_reset_xor got=%h want=f0", recomb(res));
    end
  endtask

  initial begin
    test_reset();
    test_not();
    test_xor();
    test_and();
    test_and_random();
    test_stall();
    test_backpressure();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
